noc_packetizer: RTL
===================

NOC_PACKETIZER -- requirements
Module: noc_packetizer

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 32, giving the router flit width; only 32 is supported.
REQ-002 The block SHALL have parameter NODE_ID, default 4'h0, giving the local node index {row[1:0], col[1:0]} in the 4x4 mesh.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the injection FIFO depth; legal values are powers of 2 from 2 to 16.
REQ-004 The block SHALL have port clk1, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port A, input, 8 bits: operand A from the local processing element.
REQ-007 The block SHALL have port B, input, 8 bits: operand B from the local processing element.
REQ-008 The block SHALL have port K, input, 4 bits: destination node index {row, col}.
REQ-009 The block SHALL have port buffer_in, input, 1 bit: push request for A/B/K in this cycle.
REQ-010 The block SHALL have port buffer_out, output, 1 bit: busy, asserted when the FIFO is full.
REQ-011 The block SHALL have port router_in, output, BUS_WIDTH bits: the flit presented to the local router port.
REQ-012 The block SHALL have port router_in_valid, output, 1 bit: router_in holds a valid flit.
REQ-013 The block SHALL have port router_in_ready, input, 1 bit: the router accepts the flit this cycle.
REQ-014 The block SHALL have port drop_cnt, output, 8 bits: saturating count of dropped self-addressed pushes.

Function
REQ-015 The flit format SHALL be [31:28]=K, [27:24]=NODE_ID, [23:20]=seq, [19:16]=chk, [15:8]=A, [7:0]=B.
REQ-016 chk SHALL equal A[7:4]^A[3:0]^B[7:4]^B[3:0].
REQ-017 A push SHALL be accepted when buffer_in=1, buffer_out=0, K!=NODE_ID and rst=0; the flit is then built and written into the FIFO at that edge.
REQ-018 A push with K==NODE_ID while buffer_out=0 SHALL be dropped: no FIFO write, seq unchanged, drop_cnt incremented, saturating at 8'hFF.
REQ-019 A push while buffer_out=1 SHALL be ignored: no write, no seq change, no drop_cnt change.
REQ-020 seq SHALL be a 4-bit counter that advances by 1 on each accepted push and wraps from 4'hF to 4'h0.
REQ-021 buffer_out SHALL be a registered signal equal to (occupancy==DEPTH); a pop in the same cycle SHALL NOT admit a push while full.
REQ-022 router_in_valid SHALL equal (occupancy!=0); router_in SHALL show the FIFO head.
REQ-023 Push-to-valid latency SHALL be 1 cycle: a push accepted at edge n gives router_in_valid=1 after edge n when the FIFO was empty.
REQ-024 A pop SHALL occur at an edge where router_in_valid=1 and router_in_ready=1.
REQ-025 While router_in_valid=1 and router_in_ready=0, router_in SHALL remain stable.
REQ-026 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged and preserve order.
REQ-027 A simultaneous push and pop on an empty FIFO SHALL not occur, because valid is 0 in that cycle; the push is stored.
REQ-028 Flits SHALL leave in strict FIFO order, with no loss or duplication.

Reset
REQ-029 While rst=1 at an edge: occupancy=0, read/write pointers=0, seq=0, drop_cnt=0, buffer_out=0, router_in_valid=0.
REQ-030 router_in SHALL read 32'h0 after reset until the first write.
REQ-031 A reset mid-operation SHALL discard all queued flits; pushes coincident with rst=1 are ignored.

Structure
REQ-032 A shared package noc_pkg SHALL hold the flit field offsets and widths, NODE_ID_W=4, SEQ_W=4, and a checksum function, all reused by the router and the ejection stage.
REQ-033 Storage SHALL be one sub-module noc_sync_fifo (parameters WIDTH and DEPTH, registered full/empty); the packetizer holds the seq counter, drop counter and flit build logic.

Verification
REQ-034 With NODE_ID=5, push A=8'h3C, B=8'hA5, K=4'h9 -> next cycle router_in=32'h95003CA5 and router_in_valid=1.
REQ-035 Hold router_in_ready=0 and push 5 flits -> buffer_out=1 after the 4th push; the 5th is ignored; drained seq values are 0,1,2,3.
REQ-036 Push with K=4'h5 (NODE_ID=5) -> no valid, drop_cnt=1, next accepted flit has seq=0; after 300 self-pushes drop_cnt=8'hFF.
REQ-037 Push 17 flits with router_in_ready=1 -> seq runs 0..F then 0; the router sees 17 flits in order.
REQ-038 Queue 3 flits, assert rst for 1 cycle -> router_in_valid=0, buffer_out=0, seq=0, drop_cnt=0; the next push is emitted with seq=0.
REQ-039 Random push and ready traffic for 1000 cycles -> a scoreboard matches every non-dropped flit in order, and router_in is stable while stalled.

Source files
------------

// File: rtl/noc_pkg.sv
// Purpose: shared flit layout, field widths and checksum for the NoC endpoints.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package noc_pkg;

    localparam int FLIT_W    = 32;
    localparam int NODE_ID_W = 4;
    localparam int SEQ_W     = 4;
    localparam int CHK_W     = 4;
    localparam int DATA_W    = 8;

    // Bit offsets of each flit field (LSB position).
    localparam int DST_LSB = 28;
    localparam int SRC_LSB = 24;
    localparam int SEQ_LSB = 20;
    localparam int CHK_LSB = 16;
    localparam int A_LSB   = 8;
    localparam int B_LSB   = 0;

    typedef struct packed {
        logic [NODE_ID_W-1:0] dst;
        logic [NODE_ID_W-1:0] src;
        logic [SEQ_W-1:0]     seq;
        logic [CHK_W-1:0]     chk;
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
    } flit_t;

    // Nibble-wise XOR over both operands.
    function automatic logic [CHK_W-1:0] checksum(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return a[7:4] ^ a[3:0] ^ b[7:4] ^ b[3:0];
    endfunction

    function automatic flit_t build_flit(input logic [NODE_ID_W-1:0] dst,
                                         input logic [NODE_ID_W-1:0] src,
                                         input logic [SEQ_W-1:0]     seq,
                                         input logic [DATA_W-1:0]    a,
                                         input logic [DATA_W-1:0]    b);
        flit_t f;
        f.dst = dst;
        f.src = src;
        f.seq = seq;
        f.chk = checksum(a, b);
        f.a   = a;
        f.b   = b;
        return f;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Purpose: single-clock FIFO with registered full/empty flags.
// Latency: write at edge n is visible on rd_dat after edge n (head-of-queue read).
// Backpressure: writes while full and reads while empty are ignored.
// Ports: clk/rst (sync, active-high), wr_en/wr_dat push side, rd_en/rd_dat pop side,
//        full/empty registered status flags.
module noc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_wr;
    logic             do_rd;

    assign do_wr  = wr_en & ~full;
    assign do_rd  = rd_en & ~empty;
    assign rd_dat = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage is cleared on reset so the head reads zero until the first write.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/noc_packetizer.sv
// Purpose: builds flits from local A/B/K pushes and queues them toward the router.
// Latency: push at edge n shows router_in_valid after edge n when the queue was empty.
// Backpressure: buffer_out (registered full) blocks pushes; router_in held while not ready.
// Ports: clk1/rst (sync, active-high); A, B, K, buffer_in push side; buffer_out busy;
//        router_in/router_in_valid/router_in_ready router side; drop_cnt self-push drops.
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int                   BUS_WIDTH = 32,
    parameter logic [NODE_ID_W-1:0] NODE_ID   = 4'h0,
    parameter int                   DEPTH     = 4
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic [7:0]           A,
    input  logic [7:0]           B,
    input  logic [3:0]           K,
    input  logic                 buffer_in,
    output logic                 buffer_out,
    output logic [BUS_WIDTH-1:0] router_in,
    output logic                 router_in_valid,
    input  logic                 router_in_ready,
    output logic [7:0]           drop_cnt
);

    logic [SEQ_W-1:0] seq;
    logic             push_ok;
    logic             self_push;
    flit_t            new_flit;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FLIT_W-1:0] head_dat;

    // A flit addressed to ourselves would never leave the mesh; count and drop it.
    assign self_push = buffer_in & ~buffer_out & (K == NODE_ID);
    assign push_ok   = buffer_in & ~buffer_out & (K != NODE_ID);
    assign new_flit  = build_flit(K, NODE_ID, seq, A, B);

    always_ff @(posedge clk1) begin
        if (rst) begin
            seq      <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                seq <= seq + SEQ_W'(1);
            end
            if (self_push && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    noc_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk1),
        .rst    (rst),
        .wr_en  (push_ok),
        .wr_dat (new_flit),
        .rd_en  (router_in_ready),
        .rd_dat (head_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign buffer_out      = fifo_full;
    assign router_in_valid = ~fifo_empty;
    assign router_in       = head_dat;

endmodule
